// File: rtl/ysyx_25060170_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch unit.
package ysyx_25060170_fetch_pkg;

  localparam int          ILEN         = 32;
  localparam int          DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ysyx_25060170_pc_gen.sv
// Architectural fetch PC: redirect target mux (jmp > br > step) and
// misalignment flag for the next PC.
module ysyx_25060170_pc_gen
  import ysyx_25060170_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int              PC_STEP  = DEF_PC_STEP
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_br_i,
  input  logic            ex_jmp_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_res_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_nxt_o,
  output logic            nxt_misal_o
);

  logic [XLEN-1:0] pc_q, pc_d, tgt;

  always_comb begin
    tgt  = ex_jmp_i ? (ex_res_i & ~XLEN'(1)) : (ex_pc_i + ex_imm_i);
    pc_d = pc_q;
    if (ex_jmp_i || ex_br_i) pc_d = tgt;
    else if (step_i)         pc_d = pc_q + XLEN'(PC_STEP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o        = pc_q;
  assign pc_nxt_o    = pc_d;
  assign nxt_misal_o = |pc_d[1:0];

endmodule

// File: rtl/ysyx_25060170_fetch_unit.sv
// Fetch engine: one outstanding imem request, registered instruction
// hand-off to the IDU, and EXU redirects that squash in-flight fetches.
module ysyx_25060170_fetch_unit
  import ysyx_25060170_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int              PC_STEP  = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_br,
  input  logic            ex_jmp,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_res,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  fetch_state_e    state_q, state_d;
  logic            kill_q, kill_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic            nxt_misal, redir;

  assign redir = ex_br | ex_jmp;

  ysyx_25060170_pc_gen #(.XLEN(XLEN), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .ex_br_i     (ex_br),
    .ex_jmp_i    (ex_jmp),
    .step_i      (state_q == S_HOLD && inst_ready),
    .ex_pc_i     (ex_pc),
    .ex_imm_i    (ex_imm),
    .ex_res_i    (ex_res),
    .pc_o        (pc_q),
    .pc_nxt_o    (pc_nxt),
    .nxt_misal_o (nxt_misal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= RESET_PC;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fault_q     <= fault_d;
    end
  end

  // REQ with no request raised means the pc was misaligned: fault out
  // directly unless a redirect gives us a fresh pc to try.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_valid_q) begin
          if (imem_req_ready) state_d = S_WAIT;
        end else if (!redir) begin
          state_d = S_HOLD;
        end
      end
      S_WAIT: if (imem_rsp_valid) state_d = (kill_q || redir) ? S_REQ : S_HOLD;
      S_HOLD: if (redir || inst_ready) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    kill_d      = kill_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fault_d     = fault_q;
    case (state_q)
      S_REQ: begin
        if (req_valid_q) begin
          if (imem_req_ready) req_valid_d = 1'b0;
          if (redir)          kill_d      = 1'b1;
        end else if (!redir) begin
          inst_d    = '0;
          inst_pc_d = pc_q;
          fault_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (!kill_q && !redir) begin
            inst_d    = imem_rsp_err ? '0 : imem_rsp_data;
            inst_pc_d = pc_q;
            fault_d   = imem_rsp_err;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A pending request keeps its address; only a fresh REQ samples the pc.
    if (state_d == S_REQ && !(state_q == S_REQ && req_valid_q)) begin
      req_valid_d = ~nxt_misal;
      req_addr_d  = pc_nxt;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (state_q == S_HOLD) && !redir;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = fault_q;

endmodule

// File: tb/tb_ysyx_25060170_fetch_unit.sv
// Scoreboarded bench: expected delivery stream follows the architectural
// pc (start, +4 per delivered inst, target on redirect) over a model memory.
module tb_ysyx_25060170_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_br, ex_jmp;
  logic [31:0] ex_pc, ex_imm, ex_res;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst, inst_pc;

  ysyx_25060170_fetch_unit dut (
    .clk(clk), .rst(rst), .ex_br(ex_br), .ex_jmp(ex_jmp), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_res(ex_res), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0, n_deliv = 0, n_acc = 0, cyc = 0;
  int          rsp_lat = 1, req_lo = 0, idu_lo = 0;
  bit          rsp_rand = 0, rdy_rand = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_a[$];
  int          pend_c[$];
  int          dv_cyc[$];
  bit          pre_iv, acc_now, prv_req_stall, prv_inst_stall;
  logic [31:0] acc_addr_now, prv_addr, mon_e;
  logic [64:0] prv_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] ^ a[15:0]};
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[6:2] == 5'h11;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void chk_acc(input string nm, input logic [31:0] a);
    chk(nm, {31'd0, acc_now, acc_addr_now}, {31'd0, 1'b1, a});
  endfunction

  // Monitor: pops the scoreboard on every IDU handshake.
  always @(negedge clk) begin
    #2;
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL scoreboard_empty actual pc=%0h expected=none", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("inst_pc", inst_pc, mon_e);
        chk("inst_fault", inst_fault, (mon_e[1:0] != 2'b00) || mem_err(mon_e));
        chk("inst", inst, ((mon_e[1:0] != 2'b00) || mem_err(mon_e)) ? 32'd0 : mem_word(mon_e));
        exp_q.push_back(mon_e + 32'd4);
      end
      n_deliv++;
      dv_cyc.push_back(cyc);
    end
  end

  task automatic step(input bit br, input bit jmp, input logic [31:0] p,
                      input logic [31:0] im, input logic [31:0] rs);
    logic [31:0] a;
    @(negedge clk);
    cyc++;
    pre_iv = inst_valid;
    imem_rsp_valid = 1'b0; imem_rsp_data = $urandom; imem_rsp_err = 1'b0;
    if (pend_a.size() != 0 && cyc >= pend_c[0] + rsp_lat &&
        (!rsp_rand || $urandom_range(0, 2) != 0)) begin
      a = pend_a.pop_front();
      void'(pend_c.pop_front());
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(a); imem_rsp_err = mem_err(a);
    end
    if (req_lo > 0) begin imem_req_ready = 1'b0; req_lo--; end
    else imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (idu_lo > 0) begin inst_ready = 1'b0; idu_lo--; end
    else inst_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    ex_br = br; ex_jmp = jmp; ex_pc = p; ex_imm = im; ex_res = rs;
    if (br || jmp) begin
      exp_q.delete();
      exp_q.push_back(jmp ? (rs & 32'hFFFF_FFFE) : p + im);
    end
    #1;
    if (prv_req_stall) begin
      chk("req_hold_valid", imem_req_valid, 1);
      chk("req_hold_addr", imem_req_addr, prv_addr);
    end
    if (prv_inst_stall && !(br || jmp))
      chk("inst_hold", {inst_valid, inst_pc, inst, inst_fault}, {1'b1, prv_inst});
    if (br || jmp) chk("redir_mask", inst_valid, 0);
    if (inst_valid) chk("no_req_in_hold", imem_req_valid, 0);
    acc_now = imem_req_valid && imem_req_ready;
    acc_addr_now = imem_req_addr;
    if (acc_now) begin pend_a.push_back(imem_req_addr); pend_c.push_back(cyc); n_acc++; end
    prv_req_stall  = imem_req_valid && !imem_req_ready;
    prv_addr       = imem_req_addr;
    prv_inst_stall = inst_valid && !inst_ready;
    prv_inst       = {inst_pc, inst, inst_fault};
  endtask

  task automatic nop();
    step(1'b0, 1'b0, $urandom, $urandom, $urandom);
  endtask

  task automatic rand_redir();
    logic [31:0] p, im, rs;
    int k;
    k  = $urandom_range(0, 2);
    p  = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
    case ($urandom_range(0, 7))
      0:       im = 32'($urandom_range(0, 7));
      1:       begin p = 32'hFFFF_FFF0; im = 32'h20; end
      default: im = 32'($urandom_range(0, 63)) << 2;
    endcase
    rs = 32'h8000_0000 | 32'($urandom_range(0, 1023));
    step(k != 1, k != 0, p, im, rs);
  endtask

  // Reset mid-anything; a stray response during the IDLE cycle must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ex_br = 0; ex_jmp = 0; imem_rsp_valid = 0; imem_req_ready = 1; inst_ready = 1;
    pend_a.delete(); pend_c.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, RST_PC);
    chk("rst_inst_fault", inst_fault, 0);
    exp_q.delete(); exp_q.push_back(RST_PC);
    prv_req_stall = 0; prv_inst_stall = 0;
    rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    cyc = 0;
  endtask

  initial begin
    int na, nd;
    rst = 1'b1; ex_br = 0; ex_jmp = 0; ex_pc = 0; ex_imm = 0; ex_res = 0;
    imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
    inst_ready = 1;
    do_reset();
    // Sequential fetch, one instruction per 3 cycles.
    for (int c = 1; c <= 9; c++) begin
      nop();
      if (c % 3 == 1) chk_acc("seq_addr", RST_PC + 32'((c - 1) / 3 * 4));
    end
    rsp_lat = 3;
    nop();                                                         // 10
    chk_acc("seq_addr3", 32'h8000_000C);
    chk("thruput", {16'(dv_cyc[0]), 16'(dv_cyc[1]), 16'(dv_cyc[2])}, {16'd3, 16'd6, 16'd9});
    step(1'b1, 1'b0, 32'h8000_0010, 32'h20, $urandom);             // 11: br in WAIT
    nop(); nop();                                                  // 12,13: stale rsp
    rsp_lat = 1;
    nop(); chk_acc("br_wait_tgt", 32'h8000_0030);                  // 14
    nop();                                                         // 15
    step(1'b0, 1'b1, $urandom, $urandom, 32'h8000_0105);           // 16: jmp in HOLD
    chk("hold_before_jmp", pre_iv, 1);
    nop(); chk_acc("jmp_tgt", 32'h8000_0104);                      // 17
    nop(); nop(); nop(); nop();                                    // 18-21
    na = n_acc;
    step(1'b1, 1'b0, 32'h8000_0010, 32'h2, $urandom);              // 22: misaligned target
    nop(); chk("misal_no_req", imem_req_valid, 0);                 // 23
    nop(); chk("misal_no_acc", n_acc, na);                         // 24
    nop();                                                         // 25
    step(1'b0, 1'b1, $urandom, $urandom, 32'h8000_0040);           // 26
    nop(); chk_acc("realign", 32'h8000_0040);                      // 27
    nop(); nop(); nop(); chk_acc("err_addr", 32'h8000_0044);       // 28-30
    nop(); nop(); nop(); chk_acc("after_err", 32'h8000_0048);      // 31-33
    nop(); nop();                                                  // 34,35
    req_lo = 3;
    nop(); nop(); nop();                                           // 36-38
    nop(); chk_acc("bp_addr", 32'h8000_004C);                      // 39
    nop();                                                         // 40
    nd = n_deliv; idu_lo = 4;
    repeat (5) nop();                                              // 41-45
    nop(); chk("idu_bp_one", n_deliv, nd + 1);                     // 46
    // Random traffic with backpressure, latency and redirects.
    rsp_rand = 1; rdy_rand = 1; nd = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rand_redir();
      else nop();
    end
    chk("progress", n_deliv - nd > 100, 1);
    // Reset mid-flight, then restart cleanly.
    do_reset();
    rsp_rand = 0; rdy_rand = 0; rsp_lat = 1; nd = n_deliv;
    repeat (13) nop();
    chk("post_rst_deliv", n_deliv, nd + 4);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
